// File: rtl/led_chain_tx_if.sv
// led_chain_tx_if: frame handshake and framebuffer read port of the LED chain
// transmitter.
//   i_start  frame request into the transmitter
//   o_busy   transmitter busy (low only in IDLE)
//   o_done   one-cycle pulse after the latch strobe
//   o_addr   framebuffer word address driven by the transmitter
//   i_data   framebuffer word, valid one cycle after o_addr
// Modports: master = transmitter side, slave = host/framebuffer side.
interface led_chain_tx_if #(
   parameter int c_aw   = 9,
   parameter int c_bits = 12
);
   logic              i_start;
   logic              o_busy;
   logic              o_done;
   logic [c_aw-1:0]   o_addr;
   logic [c_bits-1:0] i_data;

   modport master (
      input  i_start,
      input  i_data,
      output o_busy,
      output o_done,
      output o_addr
   );

   modport slave (
      output i_start,
      output i_data,
      input  o_busy,
      input  o_done,
      input  o_addr
   );
endinterface

// File: rtl/led_chain_tx.sv
// led_chain_tx: serial transmitter for the LED-driver daisy chain.
// Reads one frame of grey-scale words from the framebuffer (last word first,
// since it travels farthest down the chain), shifts each word out MSB first on
// o_clk/o_dai, then strobes o_lat.
// Ports:
//   i_clk, i_rst_n  system clock, asynchronous active-low reset
//   fb (master)     i_start/o_busy/o_done handshake and o_addr -> i_data
//                   framebuffer read port (i_data valid one cycle after o_addr)
//   o_clk           serial clock to the chain, idles low
//   o_dai           serial data to the chain
//   o_lat           latch strobe to the chain
// Build option: define LED_TX_AUTO_EN for free-running refresh; after each
// DONE the block waits 2*c_div cycles in IDLE and then starts the next frame
// by itself. Without it, frames start only on i_start.
//
// state   | meaning
// S_IDLE  | waiting for i_start (or the refresh timer in auto builds)
// S_FETCH | 2 cycles: present o_addr, then capture i_data into the shifter
// S_SHIFT | c_bits bits, each c_div cycles o_clk low then c_div cycles high
// S_LATCH | o_lat high for 2*c_div cycles, o_clk/o_dai held low
// S_DONE  | one-cycle o_done pulse
module led_chain_tx #(
   parameter int c_boards   = 30,
   parameter int c_channels = 12,
   parameter int c_bits     = 12,
   parameter int c_div      = 25
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   led_chain_tx_if.master  fb,
   output logic            o_clk,
   output logic            o_dai,
   output logic            o_lat
);

   localparam int c_words = c_boards * c_channels;
   localparam int c_aw    = (c_words > 1) ? $clog2(c_words) : 1;
   localparam int c_tw    = (2 * c_div > 1) ? $clog2(2 * c_div) : 1;
   localparam int c_bw    = (c_bits > 1) ? $clog2(c_bits) : 1;

   localparam logic [c_aw-1:0] c_last_addr = c_aw'(c_words - 1);
   localparam logic [c_tw-1:0] c_half_ld   = c_tw'(c_div - 1);
   localparam logic [c_tw-1:0] c_full_ld   = c_tw'(2 * c_div - 1);
   localparam logic [c_bw-1:0] c_bit_ld    = c_bw'(c_bits - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_LATCH,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [c_aw-1:0]   addr_q, addr_d;
   logic [c_bits-1:0] shreg_q, shreg_d;
   logic [c_tw-1:0]   tmr_q, tmr_d;
   logic [c_bw-1:0]   bit_q, bit_d;
   logic              clk_hi_q, clk_hi_d;
   logic              fetch_ph_q, fetch_ph_d;
   logic              auto_go;

`ifdef LED_TX_AUTO_EN
   // Set by the first completed frame; reset clears it so a frame cut by
   // reset does not restart refresh on its own.
   logic              arm_q, arm_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         arm_q <= 1'b0;
      end else begin
         arm_q <= arm_d;
      end
   end

   assign auto_go = arm_q && (tmr_q == '0);
`else
   assign auto_go = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         shreg_q    <= '0;
         tmr_q      <= '0;
         bit_q      <= '0;
         clk_hi_q   <= 1'b0;
         fetch_ph_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         shreg_q    <= shreg_d;
         tmr_q      <= tmr_d;
         bit_q      <= bit_d;
         clk_hi_q   <= clk_hi_d;
         fetch_ph_q <= fetch_ph_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      shreg_d    = shreg_q;
      tmr_d      = tmr_q;
      bit_d      = bit_q;
      clk_hi_d   = clk_hi_q;
      fetch_ph_d = fetch_ph_q;
`ifdef LED_TX_AUTO_EN
      arm_d      = arm_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (fb.i_start || auto_go) begin
               state_d    = S_FETCH;
               addr_d     = c_last_addr;
               fetch_ph_d = 1'b0;
            end
`ifdef LED_TX_AUTO_EN
            else if (arm_q) begin
               tmr_d = tmr_q - 1'b1;
            end
`endif
         end

         S_FETCH: begin
            // First cycle only presents the address; the word arrives on the second.
            if (!fetch_ph_q) begin
               fetch_ph_d = 1'b1;
            end else begin
               fetch_ph_d = 1'b0;
               shreg_d    = fb.i_data;
               tmr_d      = c_half_ld;
               bit_d      = c_bit_ld;
               clk_hi_d   = 1'b0;
               state_d    = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               tmr_d = c_half_ld;
               if (!clk_hi_q) begin
                  clk_hi_d = 1'b1;
               end else begin
                  // Falling o_clk: advance to the next bit so o_dai only
                  // changes while o_clk is low.
                  clk_hi_d = 1'b0;
                  shreg_d  = shreg_q << 1;
                  if (bit_q != '0) begin
                     bit_d = bit_q - 1'b1;
                  end else if (addr_q == '0) begin
                     tmr_d   = c_full_ld;
                     state_d = S_LATCH;
                  end else begin
                     addr_d     = addr_q - 1'b1;
                     fetch_ph_d = 1'b0;
                     state_d    = S_FETCH;
                  end
               end
            end
         end

         S_LATCH: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
`ifdef LED_TX_AUTO_EN
            tmr_d = c_full_ld;
            arm_d = 1'b1;
`endif
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fb.o_busy = (state_q != S_IDLE);
   assign fb.o_done = (state_q == S_DONE);
   assign fb.o_addr = addr_q;
   assign o_clk     = (state_q == S_SHIFT) && clk_hi_q;
   assign o_dai     = (state_q == S_SHIFT) && shreg_q[c_bits-1];
   assign o_lat     = (state_q == S_LATCH);

endmodule

// File: tb/tb_led_chain_tx.sv
// tb_led_chain_tx: bench for led_chain_tx.
// Instance A: 2 boards x 2 channels, 4-bit words, c_div=1 (W=4, frame=43).
// Instance B: 1 word of 12 bits, c_div=3 (divider checks).
// Expected serial streams are built from framebuffer contents (last word
// first, MSB first); timing from the word/frame length formulas.
module tb_led_chain_tx;
   localparam int BOARDS_A = 2;
   localparam int CH_A     = 2;
   localparam int BITS_A   = 4;
   localparam int DIV_A    = 1;
   localparam int W_A      = BOARDS_A * CH_A;
   localparam int AW_A     = (W_A > 1) ? $clog2(W_A) : 1;
   localparam int WORD_A   = 2 + 2 * DIV_A * BITS_A;
   localparam int FRAME_A  = W_A * WORD_A + 2 * DIV_A + 1;

   localparam int BITS_B   = 12;
   localparam int DIV_B    = 3;
   localparam int FRAME_B  = 1 * (2 + 2 * DIV_B * BITS_B) + 2 * DIV_B + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   led_chain_tx_if #(.c_aw(AW_A), .c_bits(BITS_A)) fa ();
   led_chain_tx_if #(.c_aw(1), .c_bits(BITS_B)) fbb ();

   logic a_clk, a_dai, a_lat;
   logic b_clk, b_dai, b_lat;

   led_chain_tx #(
      .c_boards(BOARDS_A), .c_channels(CH_A), .c_bits(BITS_A), .c_div(DIV_A)
   ) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .fb(fa.master),
      .o_clk(a_clk), .o_dai(a_dai), .o_lat(a_lat)
   );

   led_chain_tx #(
      .c_boards(1), .c_channels(1), .c_bits(BITS_B), .c_div(DIV_B)
   ) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .fb(fbb.master),
      .o_clk(b_clk), .o_dai(b_dai), .o_lat(b_lat)
   );

   // Framebuffers with one cycle read latency.
   logic [BITS_A-1:0] mem_a [W_A];
   logic [BITS_B-1:0] mem_b;
   always @(posedge clk) begin
      fa.i_data  <= mem_a[fa.o_addr];
      fbb.i_data <= mem_b;
   end

   int n_asserts = 0;
   int n_fail = 0;

   // Monitor A (sampled mid-cycle).
   int cyc = 0;
   bit bits_a[$];
   int addrs_a[$];
   logic clk_prev_a = 1'b0, busy_prev_a = 1'b0, dai_prev_a = 1'b0;
   int lat_a = 0, lat_run_a = 0, lat_w_a = 0, ovl_a = 0;
   int hi_run_a = 0, bad_hi_a = 0, dai_chg_a = 0;
   int done_cnt_a = 0, done_cyc_a = 0, rise_cnt_a = 0, rise_cyc_a = 0, fall_cyc_a = 0;

   always @(negedge clk) begin
      cyc         <= cyc + 1;
      clk_prev_a  <= a_clk;
      busy_prev_a <= fa.o_busy;
      dai_prev_a  <= a_dai;
      if (a_clk && !clk_prev_a) begin
         bits_a.push_back(a_dai);
         addrs_a.push_back(int'(fa.o_addr));
      end
      if (a_clk && clk_prev_a && (a_dai != dai_prev_a)) dai_chg_a <= dai_chg_a + 1;
      if (a_clk) hi_run_a <= hi_run_a + 1;
      else if (hi_run_a != 0) begin
         if (hi_run_a != DIV_A) bad_hi_a <= bad_hi_a + 1;
         hi_run_a <= 0;
      end
      if (a_lat) begin
         lat_a     <= lat_a + 1;
         lat_run_a <= lat_run_a + 1;
      end else if (lat_run_a != 0) begin
         lat_w_a   <= lat_run_a;
         lat_run_a <= 0;
      end
      if (a_lat && a_clk) ovl_a <= ovl_a + 1;
      if (fa.o_done) begin
         done_cnt_a <= done_cnt_a + 1;
         done_cyc_a <= cyc;
      end
      if (fa.o_busy && !busy_prev_a) begin
         rise_cnt_a <= rise_cnt_a + 1;
         rise_cyc_a <= cyc;
      end
      if (!fa.o_busy && busy_prev_a) fall_cyc_a <= cyc;
   end

   // Monitor B.
   bit bits_b[$];
   int per_b[$];
   logic clk_prev_b = 1'b0, busy_prev_b = 1'b0, dai_prev_b = 1'b0;
   int last_rise_b = -1, hi_run_b = 0, bad_hi_b = 0, dai_chg_b = 0;
   int lat_run_b = 0, lat_w_b = 0, ovl_b = 0;
   int done_cnt_b = 0, done_cyc_b = 0, rise_cyc_b = 0;

   always @(negedge clk) begin
      clk_prev_b  <= b_clk;
      busy_prev_b <= fbb.o_busy;
      dai_prev_b  <= b_dai;
      if (b_clk && !clk_prev_b) begin
         bits_b.push_back(b_dai);
         if (last_rise_b >= 0) per_b.push_back(cyc - last_rise_b);
         last_rise_b <= cyc;
      end
      if (b_clk && clk_prev_b && (b_dai != dai_prev_b)) dai_chg_b <= dai_chg_b + 1;
      if (b_clk) hi_run_b <= hi_run_b + 1;
      else if (hi_run_b != 0) begin
         if (hi_run_b != DIV_B) bad_hi_b <= bad_hi_b + 1;
         hi_run_b <= 0;
      end
      if (b_lat) lat_run_b <= lat_run_b + 1;
      else if (lat_run_b != 0) begin
         lat_w_b   <= lat_run_b;
         lat_run_b <= 0;
      end
      if (b_lat && b_clk) ovl_b <= ovl_b + 1;
      if (fbb.o_done) begin
         done_cnt_b <= done_cnt_b + 1;
         done_cyc_b <= cyc;
      end
      if (fbb.o_busy && !busy_prev_b) rise_cyc_b <= cyc;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_a();
      fa.i_start = 1'b1;
      tick(1);
      fa.i_start = 1'b0;
   endtask

   task automatic wait_done_a(input string tag);
      int base = done_cnt_a;
      int n = 0;
      while (done_cnt_a == base && n < 2000) begin
         tick(1);
         n++;
      end
      chk({tag, "_done_seen"}, done_cnt_a - base, 1);
   endtask

   task automatic wait_sig_a(input string tag, input bit want_lat);
      int n = 0;
      while (((want_lat ? a_lat : a_clk) !== 1'b1) && n < 200) begin
         tick(1);
         n++;
      end
      chk({tag, "_reached"}, int'(want_lat ? a_lat : a_clk), 1);
   endtask

   // Reference model: expected stream is every word from W-1 down to 0, MSB first.
   task automatic check_frame_a(input string tag, input int b0);
      int exp_word = 0;
      int got_word = 0;
      int addr_bad = 0;
      int k = 0;
      for (int a = W_A - 1; a >= 0; a--) begin
         for (int i = BITS_A - 1; i >= 0; i--) begin
            exp_word = (exp_word << 1) | int'(mem_a[a][i]);
            if (b0 + k < bits_a.size()) begin
               got_word = (got_word << 1) | int'(bits_a[b0 + k]);
               if (addrs_a[b0 + k] != a) addr_bad++;
            end
            k++;
         end
      end
      chk({tag, "_pulses"}, bits_a.size() - b0, W_A * BITS_A);
      chk({tag, "_bits"}, got_word, exp_word);
      chk({tag, "_addr_seq"}, addr_bad, 0);
      chk({tag, "_done_offset"}, done_cyc_a - rise_cyc_a, FRAME_A - 1);
      chk({tag, "_busy_len"}, fall_cyc_a - rise_cyc_a, FRAME_A);
      chk({tag, "_lat_width"}, lat_w_a, 2 * DIV_A);
      chk({tag, "_lat_clk_overlap"}, ovl_a, 0);
      chk({tag, "_clk_hi_width"}, bad_hi_a, 0);
      chk({tag, "_dai_stable"}, dai_chg_a, 0);
   endtask

   task automatic settle();
`ifdef LED_TX_AUTO_EN
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
`endif
      tick(3);
   endtask

   initial begin
      int b0, b1, r0, d0, l0, dd, n, got, bad;
      fa.i_start  = 1'b0;
      fbb.i_start = 1'b0;
      mem_b = '0;
      for (int i = 0; i < W_A; i++) mem_a[i] = '0;
      rst_n = 1'b0;
      tick(3);

      // Reset state
      chk("rst_busy", int'(fa.o_busy), 0);
      chk("rst_done", int'(fa.o_done), 0);
      chk("rst_clk", int'(a_clk), 0);
      chk("rst_dai", int'(a_dai), 0);
      chk("rst_lat", int'(a_lat), 0);
      chk("rst_addr", int'(fa.o_addr), 0);
      rst_n = 1'b1;
      tick(20);
      chk("idle_no_start", rise_cnt_a, 0);

      // Directed frame
      mem_a[0] = 4'hA; mem_a[1] = 4'h5; mem_a[2] = 4'hF; mem_a[3] = 4'h1;
      b0 = bits_a.size();
      pulse_a();
      wait_done_a("f0");
      tick(2);
      check_frame_a("f0", b0);
      chk("f0_one_done", done_cnt_a, 1);
      settle();

      // Random frames
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < W_A; i++) mem_a[i] = BITS_A'($urandom_range(0, (1 << BITS_A) - 1));
         b0 = bits_a.size();
         pulse_a();
         wait_done_a("rnd");
         tick(2);
         check_frame_a($sformatf("rnd%0d", f), b0);
         settle();
      end

      // i_start while busy is ignored
      for (int i = 0; i < W_A; i++) mem_a[i] = BITS_A'($urandom_range(0, (1 << BITS_A) - 1));
      b0 = bits_a.size(); r0 = rise_cnt_a; d0 = done_cnt_a;
      pulse_a();
      wait_sig_a("busy_shift", 1'b0);
      pulse_a();
      wait_sig_a("busy_latch", 1'b1);
      pulse_a();
      wait_done_a("busy");
      tick(2);
      check_frame_a("busy", b0);
      chk("busy_frames", rise_cnt_a - r0, 1);
      chk("busy_dones", done_cnt_a - d0, 1);
      settle();

      // Back-to-back with i_start held high
      for (int i = 0; i < W_A; i++) mem_a[i] = BITS_A'($urandom_range(0, (1 << BITS_A) - 1));
      b0 = bits_a.size(); r0 = rise_cnt_a;
      fa.i_start = 1'b1;
      wait_done_a("b2b1");
      dd = done_cyc_a;
      n = 0;
      while (rise_cnt_a < r0 + 2 && n < 20) begin
         tick(1);
         n++;
      end
      chk("b2b_second_start", rise_cnt_a - r0, 2);
      chk("b2b_fetch_gap", rise_cyc_a - dd, 2);
      chk("b2b_idle_cycle", fall_cyc_a - dd, 1);
      b1 = bits_a.size();
      chk("b2b_first_pulses", b1 - b0, W_A * BITS_A);
      fa.i_start = 1'b0;
      wait_done_a("b2b2");
      tick(2);
      check_frame_a("b2b2", b1);
      settle();

      // Reset mid-SHIFT
      l0 = lat_a;
      pulse_a();
      wait_sig_a("rst_mid", 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", int'(fa.o_busy), 0);
      chk("rstmid_clk", int'(a_clk), 0);
      chk("rstmid_dai", int'(a_dai), 0);
      chk("rstmid_lat", int'(a_lat), 0);
      chk("rstmid_addr", int'(fa.o_addr), 0);
      tick(2);
      rst_n = 1'b1;
      r0 = rise_cnt_a;
      tick(25);
      chk("rstmid_no_latch", lat_a - l0, 0);
      chk("rstmid_no_restart", rise_cnt_a - r0, 0);
      chk("rstmid_idle", int'(fa.o_busy), 0);

      // Free-running refresh (auto build) or staying idle (default build)
      r0 = rise_cnt_a;
      pulse_a();
      wait_done_a("auto1");
      dd = done_cyc_a;
`ifdef LED_TX_AUTO_EN
      n = 0;
      while (rise_cnt_a < r0 + 2 && n < 40) begin
         tick(1);
         n++;
      end
      chk("auto_restart", rise_cnt_a - r0, 2);
      chk("auto_gap", rise_cyc_a - dd, 2 * DIV_A + 1);
      wait_done_a("auto2");
      dd = done_cyc_a;
      n = 0;
      while (rise_cnt_a < r0 + 3 && n < 40) begin
         tick(1);
         n++;
      end
      chk("auto_gap2", rise_cyc_a - dd, 2 * DIV_A + 1);
      settle();
`else
      tick(40);
      chk("no_auto_frame", rise_cnt_a - r0, 1);
      chk("no_auto_idle", int'(fa.o_busy), 0);
`endif

      // Divider instance
      mem_b = BITS_B'($urandom_range(0, (1 << BITS_B) - 1));
      b0 = bits_b.size();
      fbb.i_start = 1'b1;
      tick(1);
      fbb.i_start = 1'b0;
      n = 0;
      while (done_cnt_b == 0 && n < 500) begin
         tick(1);
         n++;
      end
      chk("div_done_seen", done_cnt_b, 1);
      tick(2);
      chk("div_pulses", bits_b.size() - b0, BITS_B);
      got = 0;
      for (int i = 0; i < bits_b.size() - b0; i++) got = (got << 1) | int'(bits_b[b0 + i]);
      chk("div_bits", got, int'(mem_b));
      bad = 0;
      foreach (per_b[i]) if (per_b[i] != 2 * DIV_B) bad++;
      chk("div_period_count", per_b.size(), BITS_B - 1);
      chk("div_period", bad, 0);
      chk("div_hi_width", bad_hi_b, 0);
      chk("div_lat_width", lat_w_b, 2 * DIV_B);
      chk("div_lat_clk_overlap", ovl_b, 0);
      chk("div_dai_stable", dai_chg_b, 0);
      chk("div_done_offset", done_cyc_b - rise_cyc_b, FRAME_B - 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed still running expected finished");
      $fatal(1, "timeout");
   end
endmodule
